// File: rtl/bagging_seq_ctrl.sv
// Bagging-ensemble sequencer: streams weights into three learner memories, sweeps them for inference,
// returns the vote over valid/ack. All outputs registered (1-cycle latency); w_ready stalls the loader, HOLD waits on result_ack.
module bagging_seq_ctrl #(
    parameter int N_WEIGHTS = 32,
    parameter int AW        = 5,
    parameter int WW        = 9,
    parameter int TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          run_start,
    input  logic          w_valid,
    input  logic [WW-1:0] w_data,
    output logic          w_ready,
    output logic [2:0]    mem_write,
    output logic [2:0]    mem_read,
    output logic [AW-1:0] mem_addr,
    output logic [WW-1:0] mem_wdata,
    output logic          learner_en,
    input  logic          ens_ready,
    input  logic [1:0]    ens_vote,
    output logic [1:0]    result,
    output logic          result_valid,
    input  logic          result_ack,
    output logic          loaded,
    output logic          load_done,
    output logic          busy,
    output logic          err_timeout
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT_RDY, HOLD} state_t;

    localparam logic [AW-1:0] ADDR_LAST = AW'(N_WEIGHTS - 1);
    localparam logic [7:0]    CNT_LAST  = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    lidx_q, lidx_d;
    logic [7:0]    cnt_q, cnt_d;

    logic          w_ready_q, w_ready_d;
    logic [2:0]    mem_write_q, mem_write_d;
    logic [2:0]    mem_read_q, mem_read_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [WW-1:0] mem_wdata_q, mem_wdata_d;
    logic          learner_en_q, learner_en_d;
    logic [1:0]    result_q, result_d;
    logic          result_valid_q, result_valid_d;
    logic          loaded_q, loaded_d;
    logic          load_done_q, load_done_d;
    logic          busy_q, busy_d;
    logic          err_timeout_q, err_timeout_d;
    logic          beat_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            lidx_q         <= '0;
            cnt_q          <= '0;
            w_ready_q      <= 1'b0;
            mem_write_q    <= '0;
            mem_read_q     <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            learner_en_q   <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            loaded_q       <= 1'b0;
            load_done_q    <= 1'b0;
            busy_q         <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            lidx_q         <= lidx_d;
            cnt_q          <= cnt_d;
            w_ready_q      <= w_ready_d;
            mem_write_q    <= mem_write_d;
            mem_read_q     <= mem_read_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            learner_en_q   <= learner_en_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            loaded_q       <= loaded_d;
            load_done_q    <= load_done_d;
            busy_q         <= busy_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        lidx_d         = lidx_q;
        cnt_d          = cnt_q;
        w_ready_d      = w_ready_q;
        mem_write_d    = 3'b000;
        mem_read_d     = mem_read_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        learner_en_d   = learner_en_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        loaded_d       = loaded_q;
        load_done_d    = 1'b0;
        err_timeout_d  = err_timeout_q;
        beat_acc       = w_valid && w_ready_q;

        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d   = LOAD;
                    lidx_d    = 2'd0;
                    addr_d    = '0;
                    w_ready_d = 1'b1;
                end else if (run_start && loaded_q) begin
                    state_d       = RUN;
                    addr_d        = '0;
                    mem_addr_d    = '0;
                    mem_read_d    = 3'b111;
                    learner_en_d  = 1'b1;
                    err_timeout_d = 1'b0;
                end
            end
            LOAD: begin
                // The write for an accepted beat appears on the memory port the following cycle.
                if (beat_acc) begin
                    mem_write_d = 3'b001 << lidx_q;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = w_data;
                    if (addr_q == ADDR_LAST) begin
                        addr_d = '0;
                        if (lidx_q == 2'd2) begin
                            lidx_d      = 2'd0;
                            state_d     = IDLE;
                            w_ready_d   = 1'b0;
                            loaded_d    = 1'b1;
                            load_done_d = 1'b1;
                        end else begin
                            lidx_d = lidx_q + 2'd1;
                        end
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            RUN: begin
                if (addr_q == ADDR_LAST) begin
                    state_d      = WAIT_RDY;
                    addr_d       = '0;
                    cnt_d        = 8'd0;
                    mem_read_d   = 3'b000;
                    learner_en_d = 1'b0;
                end else begin
                    addr_d     = addr_q + AW'(1);
                    mem_addr_d = addr_q + AW'(1);
                end
            end
            WAIT_RDY: begin
                // A ready arriving on the final counted cycle still beats the timeout.
                if (ens_ready) begin
                    result_d       = ens_vote;
                    result_valid_d = 1'b1;
                    state_d        = HOLD;
                    cnt_d          = 8'd0;
                end else if (cnt_q == CNT_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                    cnt_d         = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (result_ack) begin
                    result_valid_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign w_ready      = w_ready_q;
    assign mem_write    = mem_write_q;
    assign mem_read     = mem_read_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign learner_en   = learner_en_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign loaded       = loaded_q;
    assign load_done    = load_done_q;
    assign busy         = busy_q;
    assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_bagging_seq_ctrl.sv
// Bench for bagging_seq_ctrl: random weight streams, run/vote, timeout and reset scenarios.
module tb_bagging_seq_ctrl;

    localparam int N  = 32;
    localparam int AW = 5;
    localparam int WW = 9;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start, run_start, w_valid, w_ready;
    logic [WW-1:0] w_data;
    logic [2:0]    mem_write, mem_read;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic          learner_en, ens_ready;
    logic [1:0]    ens_vote, result;
    logic          result_valid, result_ack, loaded, load_done, busy, err_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bagging_seq_ctrl #(.N_WEIGHTS(N), .AW(AW), .WW(WW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .run_start(run_start),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .learner_en(learner_en), .ens_ready(ens_ready), .ens_vote(ens_vote),
        .result(result), .result_valid(result_valid), .result_ack(result_ack),
        .loaded(loaded), .load_done(load_done), .busy(busy), .err_timeout(err_timeout)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [28:0] all_outs();
        return {w_ready, mem_write, mem_read, mem_addr, mem_wdata, learner_en,
                result, result_valid, loaded, load_done, busy, err_timeout};
    endfunction

    task automatic test_reset;
        rst = 1'b0; load_start = 1'b0; run_start = 1'b0; w_valid = 1'b0; w_data = '0;
        ens_ready = 1'b0; ens_vote = 2'b00; result_ack = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (all_outs() !== 29'd0) begin
            n_bad++; $display("FAIL reset_outputs: got %h, want 0", all_outs());
        end
        rst = 1'b1;
        tick();
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (busy !== 1'b0 || mem_read !== 3'b000 || learner_en !== 1'b0) begin
                n_bad++;
                $display("FAIL run_unloaded[%0d]: busy=%b mem_read=%b en=%b, want 0/000/0", i, busy, mem_read, learner_en);
            end
            tick();
        end
    endtask

    // Beat k must land in memory k/N at address k%N, one cycle after its handshake.
    task automatic test_load(input bit with_run);
        int sent = 0;
        int cyc = 0;
        int k;
        int done_cnt = 0;
        bit acc_prev = 1'b0;
        bit fin = 1'b0;
        bit last_wr;
        logic [WW-1:0] d_prev = '0;
        logic [2:0] exp_we;
        load_start = 1'b1;
        run_start  = with_run;
        tick();
        load_start = 1'b0;
        run_start  = 1'b0;
        while (!fin && cyc < 12 * N) begin
            k = sent - 1;
            last_wr = acc_prev && (k == 3 * N - 1);
            exp_we = acc_prev ? (3'b001 << (k / N)) : 3'b000;
            n_cmp++;
            if (mem_write !== exp_we) begin
                n_bad++; $display("FAIL load_we[cyc %0d]: got %b, want %b", cyc, mem_write, exp_we);
            end
            if (acc_prev) begin
                n_cmp++;
                if (mem_addr !== AW'(k % N) || mem_wdata !== d_prev) begin
                    n_bad++;
                    $display("FAIL load_wr[beat %0d]: addr=%0d data=%h, want addr=%0d data=%h", k, mem_addr, mem_wdata, k % N, d_prev);
                end
            end
            n_cmp++;
            if (load_done !== last_wr || loaded !== (with_run || last_wr)) begin
                n_bad++;
                $display("FAIL load_flags[cyc %0d]: load_done=%b loaded=%b, want %b/%b", cyc, load_done, loaded, last_wr, with_run || last_wr);
            end
            n_cmp++;
            if (w_ready !== (sent < 3 * N) || busy !== (sent < 3 * N) || mem_read !== 3'b000) begin
                n_bad++;
                $display("FAIL load_ctrl[cyc %0d]: w_ready=%b busy=%b mem_read=%b, want %b/%b/000", cyc, w_ready, busy, mem_read, sent < 3 * N, sent < 3 * N);
            end
            if (load_done === 1'b1) done_cnt++;
            if (last_wr) fin = 1'b1;
            run_start = with_run && !fin && ($urandom_range(0, 3) == 0);
            w_valid   = (cyc % 3 != 2) && (sent < 3 * N);
            w_data    = WW'($urandom);
            acc_prev  = w_valid && (w_ready === 1'b1);
            if (acc_prev) begin
                d_prev = w_data;
                sent++;
            end
            tick();
            cyc++;
        end
        w_valid   = 1'b0;
        run_start = 1'b0;
        n_cmp++;
        if (!fin) begin
            n_bad++; $display("FAIL load_bound: sent=%0d after %0d cycles, want %0d", sent, cyc, 3 * N);
        end
        n_cmp++;
        if (loaded !== 1'b1 || load_done !== 1'b0 || busy !== 1'b0 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL load_end: loaded=%b load_done=%b busy=%b pulses=%0d, want 1/0/0/1", loaded, load_done, busy, done_cnt);
        end
    endtask

    task automatic test_run(input logic [1:0] vote, input int delay);
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (mem_read !== 3'b111 || learner_en !== 1'b1 || mem_addr !== AW'(i) || busy !== 1'b1 || err_timeout !== 1'b0) begin
                n_bad++;
                $display("FAIL run_sweep[%0d]: rd=%b en=%b addr=%0d busy=%b err=%b, want 111/1/%0d/1/0", i, mem_read, learner_en, mem_addr, busy, err_timeout, i);
            end
            ens_vote = 2'($urandom);
            tick();
        end
        for (int j = 0; j <= delay; j++) begin
            n_cmp++;
            if (mem_read !== 3'b000 || learner_en !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b1 || err_timeout !== 1'b0) begin
                n_bad++;
                $display("FAIL wait_rdy[%0d]: rd=%b en=%b rv=%b busy=%b err=%b, want 000/0/0/1/0", j, mem_read, learner_en, result_valid, busy, err_timeout);
            end
            ens_ready = (j == delay);
            if (j == delay) ens_vote = vote;
            tick();
        end
        ens_ready = 1'b0;
        ens_vote  = ~vote;
        for (int h = 0; h < 10; h++) begin
            n_cmp++;
            if (result !== vote || result_valid !== 1'b1 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL hold[%0d]: result=%b rv=%b busy=%b, want %b/1/1", h, result, result_valid, busy, vote);
            end
            result_ack = (h == 9);
            tick();
        end
        result_ack = 1'b0;
        n_cmp++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || result !== vote || err_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL after_ack: rv=%b busy=%b result=%b err=%b, want 0/0/%b/0", result_valid, busy, result, err_timeout, vote);
        end
    endtask

    task automatic test_timeout;
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        repeat (N) tick();
        for (int j = 0; j < TO; j++) begin
            n_cmp++;
            if (busy !== 1'b1 || result_valid !== 1'b0 || err_timeout !== 1'b0) begin
                n_bad++;
                $display("FAIL timeout_wait[%0d]: busy=%b rv=%b err=%b, want 1/0/0", j, busy, result_valid, err_timeout);
            end
            ens_vote = 2'($urandom);
            tick();
        end
        n_cmp++;
        if (err_timeout !== 1'b1 || result_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_abort: err=%b rv=%b busy=%b, want 1/0/0", err_timeout, result_valid, busy);
        end
        repeat (5) tick();
        n_cmp++;
        if (err_timeout !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL timeout_sticky: err=%b busy=%b, want 1/0", err_timeout, busy);
        end
    endtask

    task automatic test_reset_mid_load;
        int sent = 0;
        int cyc = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        while (sent < 40 && cyc < 200) begin
            w_valid = 1'b1;
            w_data  = WW'($urandom);
            if (w_ready === 1'b1) sent++;
            tick();
            cyc++;
        end
        w_valid = 1'b1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (all_outs() !== 29'd0 || sent != 40) begin
            n_bad++; $display("FAIL mid_load_reset: outs=%h beats=%0d, want 0/40", all_outs(), sent);
        end
        w_valid = 1'b0;
        #1;
        rst = 1'b1;
        tick();
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (busy !== 1'b0 || mem_read !== 3'b000 || loaded !== 1'b0) begin
                n_bad++;
                $display("FAIL run_after_reset[%0d]: busy=%b rd=%b loaded=%b, want 0/000/0", i, busy, mem_read, loaded);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load(1'b0);
        test_run(2'b11, 5);
        test_run(2'b01, $urandom_range(0, 20));
        test_run(2'b00, $urandom_range(0, 20));
        test_timeout();
        test_run(2'b01, TO - 1);
        test_load(1'b1);
        test_run(2'b11, 0);
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
